// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the conv2d datapath.
// Holds default widths, FSM state type, clog2 and sign-magnitude conversions.
package conv_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_FIXED_POINT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Magnitude in, two's complement out; sign with a zero magnitude gives 0.
  function automatic logic [63:0] sm_to_tc(
    input logic        sign,
    input logic [63:0] mag
  );
    return sign ? (64'd0 - mag) : mag;
  endfunction

  // Returns {sat, data}; data uses bit dw-1 as sign, magnitude below it.
  // A negative acc always has a non-zero magnitude, so zero stays positive.
  function automatic logic [64:0] tc_to_sm(
    input logic [63:0] acc,
    input int          dw
  );
    logic        neg;
    logic [63:0] mag;
    logic [63:0] sbit;
    logic [63:0] lim;
    neg  = acc[63];
    mag  = neg ? (64'd0 - acc) : acc;
    sbit = 64'd1 << (dw - 1);
    lim  = sbit - 64'd1;
    if (mag > lim) begin
      return {1'b1, (neg ? sbit : 64'd0) | lim};
    end
    return {1'b0, (neg ? sbit : 64'd0) | mag};
  endfunction

endpackage

// File: rtl/conv_mac_scheduler_mult.sv
// Combinational sign-magnitude fixed-point multiplier.
// Ports: i_a, i_b operands; o_p product (magnitude truncated, not saturated).
module conv_mac_scheduler_mult #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIXED_POINT = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_p
);

  localparam int MW = DATA_WIDTH - 1;
  localparam int HW = MW - FIXED_POINT;

  logic [2*MW-1:0]        w_full;
  logic [HW-1:0]          w_unused_hi;
  logic [MW-1:0]          w_mag;
  logic [FIXED_POINT-1:0] w_unused_lo;

  assign w_full = {{MW{1'b0}}, i_a[MW-1:0]}
                * {{MW{1'b0}}, i_b[MW-1:0]};

  // Keep only the magnitude window aligned to the fixed point.
  assign {w_unused_hi, w_mag, w_unused_lo} = w_full;

  assign o_p = {i_a[MW] ^ i_b[MW], w_mag};

endmodule

// File: rtl/conv_mac_scheduler.sv
// Shares one multiplier across a KSIZE x KSIZE window, one product/cycle.
// Ports: clk, reset (async high); in_valid/in_ready + in_window/in_weights;
//        out_valid/out_ready + out_data/out_sat; busy (RUN or DONE).
module conv_mac_scheduler
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIXED_POINT = DEF_FIXED_POINT,
  parameter int KSIZE       = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   in_window,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   in_weights,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_sat,
  output logic                                busy
);

  localparam int N         = KSIZE * KSIZE;
  localparam int ACC_WIDTH = DATA_WIDTH + clog2(N);
  localparam int IDX_W     = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int BUS_W     = N * DATA_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [BUS_W-1:0]      r_win;
  logic [BUS_W-1:0]      r_wgt;
  logic [IDX_W-1:0]      r_idx;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_sat;

  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_prod;
  logic                  w_last;
  logic [63:0]           w_mag64;
  logic [63-ACC_WIDTH:0] w_unused_ptc;
  logic [ACC_WIDTH-1:0]  w_p_tc;
  logic [ACC_WIDTH-1:0]  w_acc_next;
  logic [63:0]           w_acc64;
  logic                  w_sat;
  logic [63-DATA_WIDTH:0] w_unused_sm;
  logic [DATA_WIDTH-1:0] w_res;

  assign w_a    = r_win[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_b    = r_wgt[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_last = (r_idx == IDX_W'(N - 1));

  conv_mac_scheduler_mult #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIXED_POINT(FIXED_POINT)
  ) u_mult (
    .i_a(w_a),
    .i_b(w_b),
    .o_p(w_prod)
  );

  assign w_mag64 = {{(64-(DATA_WIDTH-1)){1'b0}},
                    w_prod[DATA_WIDTH-2:0]};

  assign {w_unused_ptc, w_p_tc} =
    sm_to_tc(w_prod[DATA_WIDTH-1], w_mag64);

  assign w_acc_next = r_acc + w_p_tc;

  assign w_acc64 = {{(64-ACC_WIDTH){w_acc_next[ACC_WIDTH-1]}},
                    w_acc_next};

  assign {w_sat, w_unused_sm, w_res} = tc_to_sm(w_acc64, DATA_WIDTH);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_win      <= '0;
      r_wgt      <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_win <= in_window;
            r_wgt <= in_weights;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + IDX_W'(1);
          // Final product is folded in directly so DONE starts valid.
          if (w_last) begin
            r_out_data <= w_res;
            r_out_sat  <= w_sat;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Directed self-checking bench for conv_mac_scheduler.
// Scenario tasks run in sequence and print a single summary line.
module tb_conv_mac_scheduler;

  localparam int DW = 32;
  localparam int N  = 9;

  typedef logic [N*DW-1:0] bus_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  bus_t          in_window;
  bus_t          in_weights;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sat;
  logic          busy;

  int checks;
  int failures;

  conv_mac_scheduler #(
    .DATA_WIDTH (32),
    .FIXED_POINT(16),
    .KSIZE      (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_window (in_window),
    .in_weights(in_weights),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bus_t fill(input logic [31:0] v);
    bus_t b;
    for (int i = 0; i < N; i++) b[i*DW +: DW] = v;
    return b;
  endfunction

  // Present a window, return cycles from accept edge to out_valid.
  task automatic send_window(
    input  bus_t        win,
    input  bus_t        wgt,
    output int          lat,
    output logic [31:0] data,
    output logic        sat
  );
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid   = 1'b1;
    in_window  = win;
    in_weights = wgt;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_window  = fill(32'hDEADBEEF);
    in_weights = fill(32'h5A5A5A5A);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    data = out_data;
    sat  = out_sat;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_ctrl got rdy=%b vld=%b busy=%b exp 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_data !== 32'h0 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL rst_data got %h/%b exp 00000000/0",
               out_data, out_sat);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle got rdy=%b vld=%b busy=%b exp 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_identity();
    int          lat;
    logic [31:0] d;
    logic        s;
    send_window(fill(32'h00010000), fill(32'h00010000), lat, d, s);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL t1_latency got %0d exp 9", lat);
    end
    checks++;
    if (d !== 32'h00090000 || s !== 1'b0) begin
      failures++;
      $display("FAIL t1_data got %h/%b exp 00090000/0", d, s);
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL t1_release got vld=%b rdy=%b exp 0 1",
               out_valid, in_ready);
    end
    checks++;
    if (out_data !== 32'h00090000) begin
      failures++;
      $display("FAIL t1_hold got %h exp 00090000", out_data);
    end
  endtask

  task automatic test_alternate();
    int          lat;
    logic [31:0] d;
    logic        s;
    bus_t        wgt;
    for (int i = 0; i < N; i++)
      wgt[i*DW +: DW] = (i % 2 == 0) ? 32'h00008000 : 32'h80008000;
    send_window(fill(32'h00020000), wgt, lat, d, s);
    checks++;
    if (d !== 32'h00010000 || s !== 1'b0) begin
      failures++;
      $display("FAIL t2_alt got %h/%b exp 00010000/0", d, s);
    end
    drain();
  endtask

  task automatic test_negative();
    int          lat;
    logic [31:0] d;
    logic        s;
    send_window(fill(32'h00010000), fill(32'h80010000), lat, d, s);
    checks++;
    if (d !== 32'h80090000 || s !== 1'b0) begin
      failures++;
      $display("FAIL t3_neg got %h/%b exp 80090000/0", d, s);
    end
    drain();
    send_window(fill(32'h00000000), fill(32'h80010000), lat, d, s);
    checks++;
    if (d !== 32'h00000000 || s !== 1'b0) begin
      failures++;
      $display("FAIL t3_negzero got %h/%b exp 00000000/0", d, s);
    end
    drain();
  endtask

  task automatic test_saturate();
    int          lat;
    logic [31:0] d;
    logic        s;
    send_window(fill(32'h40000000), fill(32'h00010000), lat, d, s);
    checks++;
    if (d !== 32'h7FFFFFFF || s !== 1'b1) begin
      failures++;
      $display("FAIL t4_satpos got %h/%b exp 7fffffff/1", d, s);
    end
    drain();
    send_window(fill(32'h40000000), fill(32'h80010000), lat, d, s);
    checks++;
    if (d !== 32'hFFFFFFFF || s !== 1'b1) begin
      failures++;
      $display("FAIL t4_satneg got %h/%b exp ffffffff/1", d, s);
    end
    drain();
  endtask

  // Distinct pixel per index: 0+1+...+8 = 36.0
  task automatic test_index_order();
    int          lat;
    logic [31:0] d;
    logic        s;
    bus_t        win;
    for (int i = 0; i < N; i++) win[i*DW +: DW] = 32'(i) << 16;
    send_window(win, fill(32'h00010000), lat, d, s);
    checks++;
    if (d !== 32'h00240000 || s !== 1'b0) begin
      failures++;
      $display("FAIL idx_order got %h/%b exp 00240000/0", d, s);
    end
    drain();
  endtask

  // 32767.0 * 2.0 = 0xFFFE0000 raw; top magnitude bit drops.
  task automatic test_truncate();
    int          lat;
    logic [31:0] d;
    logic        s;
    bus_t        win;
    bus_t        wgt;
    win = fill(32'h7FFF0000);
    wgt = fill(32'h00000000);
    wgt[0 +: DW] = 32'h00020000;
    send_window(win, wgt, lat, d, s);
    checks++;
    if (d !== 32'h7FFE0000 || s !== 1'b0) begin
      failures++;
      $display("FAIL trunc got %h/%b exp 7ffe0000/0", d, s);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] d;
    logic        s;
    send_window(fill(32'h00010000), fill(32'h00030000), lat, d, s);
    checks++;
    if (d !== 32'h001B0000) begin
      failures++;
      $display("FAIL bp_first got %h exp 001b0000", d);
    end
    in_valid   = 1'b1;
    in_window  = fill(32'h00020000);
    in_weights = fill(32'h00010000);
    out_ready  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_data !== 32'h001B0000) begin
        failures++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b d=%h exp 1 0 001b0000",
                 k, out_valid, in_ready, out_data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_handshake got vld=%b rdy=%b busy=%b exp 0 1 0",
               out_valid, in_ready, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept got rdy=%b busy=%b exp 0 1",
               in_ready, busy);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 9 || out_data !== 32'h00120000 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL bp_second got lat=%0d d=%h s=%b exp 9 00120000 0",
               lat, out_data, out_sat);
    end
    drain();
  endtask

  task automatic test_reset_mid_run();
    int          lat;
    logic [31:0] d;
    logic        s;
    @(negedge clk);
    in_valid   = 1'b1;
    in_window  = fill(32'h00010000);
    in_weights = fill(32'h00010000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_data !== 32'h0 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL midrst got rdy=%b vld=%b busy=%b d=%h s=%b exp 1 0 0 0 0",
               in_ready, out_valid, busy, out_data, out_sat);
    end
    @(negedge clk);
    reset = 1'b0;
    send_window(fill(32'h00010000), fill(32'h00010000), lat, d, s);
    checks++;
    if (lat !== 9 || d !== 32'h00090000 || s !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after got lat=%0d d=%h s=%b exp 9 00090000 0",
               lat, d, s);
    end
    drain();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_window  = '0;
    in_weights = '0;
    test_reset();
    test_identity();
    test_alternate();
    test_negative();
    test_saturate();
    test_index_order();
    test_truncate();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
